// File: rtl/audio_fifo_sequencer.sv
// Transport FSM and two-source arbiter feeding the audio FIFO write port under watermark flow control.
// Write strobe/data registered one cycle after acceptance; ready is combinational and drops on full/high watermark/stop.
module audio_fifo_sequencer #(
    parameter int DATA_W  = 32,
    parameter int USED_W  = 12,
    parameter int HI_WM   = 3584,
    parameter int PREFILL = 1024,
    parameter int UCNT_W  = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              cmd_play,
    input  logic              cmd_pause,
    input  logic              cmd_stop,
    input  logic              src_sel,
    input  logic [DATA_W-1:0] syn_data,
    input  logic              syn_valid,
    output logic              syn_ready,
    input  logic [DATA_W-1:0] pb_data,
    input  logic              pb_valid,
    output logic              pb_ready,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic [USED_W-1:0] fifo_used,
    output logic              fifo_wrreq,
    output logic [DATA_W-1:0] fifo_data,
    output logic              out_pause,
    output logic              out_stop,
    output logic [1:0]        state,
    output logic [UCNT_W-1:0] underrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_PLAY    = 2'd2,
        ST_PAUSED  = 2'd3
    } state_t;

    localparam logic [USED_W-1:0] LP_HI_LIM  = USED_W'(HI_WM - 2);
    localparam logic [USED_W-1:0] LP_PREFILL = USED_W'(PREFILL);
    localparam logic [UCNT_W-1:0] LP_UMAX    = {UCNT_W{1'b1}};

    state_t              r_state;
    state_t              w_next;
    logic                r_src;
    logic                r_wrreq;
    logic [DATA_W-1:0]   r_data;
    logic                r_out_pause;
    logic                r_out_stop;
    logic                r_empty_d;
    logic [UCNT_W-1:0]   r_ucnt;
    logic                w_ok;
    logic                w_syn_acc;
    logic                w_pb_acc;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_play && !cmd_stop && !cmd_pause)
                    w_next = ST_PREFILL;
            end
            ST_PREFILL: begin
                if (cmd_stop)
                    w_next = ST_IDLE;
                else if (cmd_pause)
                    w_next = ST_PAUSED;
                else if (fifo_used >= LP_PREFILL)
                    w_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (cmd_stop)
                    w_next = ST_IDLE;
                else if (cmd_pause)
                    w_next = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (cmd_stop)
                    w_next = ST_IDLE;
                else if (cmd_play && !cmd_pause)
                    w_next = ST_PLAY;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The 2-word margin below HI_WM absorbs the lag of fifo_used behind our registered writes.
    assign w_ok = !reset_reset && (r_state != ST_IDLE) && !cmd_stop &&
                  !fifo_full && (fifo_used < LP_HI_LIM);

    assign syn_ready = w_ok && !r_src;
    assign pb_ready  = w_ok && r_src;
    assign w_syn_acc = syn_valid && syn_ready;
    assign w_pb_acc  = pb_valid && pb_ready;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state     <= ST_IDLE;
            r_src       <= 1'b0;
            r_wrreq     <= 1'b0;
            r_data      <= '0;
            r_out_pause <= 1'b0;
            r_out_stop  <= 1'b1;
            r_empty_d   <= 1'b0;
            r_ucnt      <= '0;
        end else begin
            r_state     <= w_next;
            r_out_stop  <= (w_next == ST_IDLE);
            r_out_pause <= (w_next == ST_PREFILL) || (w_next == ST_PAUSED);
            if (r_state == ST_IDLE && w_next == ST_PREFILL)
                r_src <= src_sel;
            r_wrreq <= w_syn_acc || w_pb_acc;
            if (w_syn_acc)
                r_data <= syn_data;
            else if (w_pb_acc)
                r_data <= pb_data;
            r_empty_d <= fifo_empty;
            if (r_state == ST_PLAY && fifo_empty && !r_empty_d && r_ucnt != LP_UMAX)
                r_ucnt <= r_ucnt + UCNT_W'(1);
        end
    end

    assign fifo_wrreq   = r_wrreq;
    assign fifo_data    = r_data;
    assign out_pause    = r_out_pause;
    assign out_stop     = r_out_stop;
    assign state        = r_state;
    assign underrun_cnt = r_ucnt;

endmodule

// File: tb/tb_audio_fifo_sequencer.sv
// Directed bench for audio_fifo_sequencer: reset, prefill, watermark table, pause/resume, stop, underrun counting.
module tb_audio_fifo_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_play, cmd_pause, cmd_stop, src_sel;
    logic [31:0] syn_data, pb_data;
    logic        syn_valid, pb_valid;
    logic        syn_ready, pb_ready;
    logic        fifo_full, fifo_empty;
    logic [11:0] fifo_used;
    logic        fifo_wrreq;
    logic [31:0] fifo_data;
    logic        out_pause, out_stop;
    logic [1:0]  state;
    logic [15:0] underrun_cnt;

    logic        s_syn_ready, s_pb_ready, s_wrreq, s_pause, s_stop;
    logic [31:0] s_data;
    logic [1:0]  s_state;
    logic [1:0]  s_cnt;

    int checks = 0;
    int errors = 0;
    logic auto_used = 1'b0;

    always #5 clk = ~clk;

    audio_fifo_sequencer dut (
        .clk_clk(clk), .reset_reset(rst),
        .cmd_play(cmd_play), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop), .src_sel(src_sel),
        .syn_data(syn_data), .syn_valid(syn_valid), .syn_ready(syn_ready),
        .pb_data(pb_data), .pb_valid(pb_valid), .pb_ready(pb_ready),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_used(fifo_used),
        .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
        .out_pause(out_pause), .out_stop(out_stop), .state(state),
        .underrun_cnt(underrun_cnt)
    );

    // Narrow counter copy so saturation is reachable in a few events.
    audio_fifo_sequencer #(.UCNT_W(2)) u_sat (
        .clk_clk(clk), .reset_reset(rst),
        .cmd_play(cmd_play), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop), .src_sel(src_sel),
        .syn_data(syn_data), .syn_valid(syn_valid), .syn_ready(s_syn_ready),
        .pb_data(pb_data), .pb_valid(pb_valid), .pb_ready(s_pb_ready),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_used(fifo_used),
        .fifo_wrreq(s_wrreq), .fifo_data(s_data),
        .out_pause(s_pause), .out_stop(s_stop), .state(s_state),
        .underrun_cnt(s_cnt)
    );

    typedef struct {
        logic [11:0] used;
        logic        full;
        logic        sv;
        logic        pv;
        logic [31:0] dat;
        logic        e_sr;
        logic        e_pr;
        logic        e_wr;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_used && fifo_wrreq)
            fifo_used = fifo_used + 12'd1;
    endtask

    initial begin
        int nwr;
        vecs[0] = '{12'd3581, 1'b0, 1'b1, 1'b0, 32'hC0DE_0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{12'd3582, 1'b0, 1'b1, 1'b0, 32'hC0DE_0001, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{12'd3583, 1'b0, 1'b1, 1'b0, 32'hC0DE_0002, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{12'd100,  1'b1, 1'b1, 1'b0, 32'hC0DE_0003, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{12'd0,    1'b0, 1'b0, 1'b0, 32'hC0DE_0004, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{12'd2000, 1'b0, 1'b1, 1'b1, 32'hC0DE_0005, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{12'd4095, 1'b0, 1'b1, 1'b1, 32'hC0DE_0006, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; cmd_play = 0; cmd_pause = 0; cmd_stop = 0; src_sel = 0;
        syn_data = 32'h0; pb_data = 32'h0; syn_valid = 0; pb_valid = 0;
        fifo_full = 0; fifo_empty = 0; fifo_used = 12'd0;
        tick(); tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_out_stop", 32'(out_stop), 32'd1);
        chk("rst_out_pause", 32'(out_pause), 32'd0);
        chk("rst_wrreq", 32'(fifo_wrreq), 32'd0);
        chk("rst_data", fifo_data, 32'd0);
        chk("rst_ucnt", 32'(underrun_cnt), 32'd0);
        chk("rst_syn_ready", 32'(syn_ready), 32'd0);
        chk("rst_pb_ready", 32'(pb_ready), 32'd0);

        // Idle with a valid synth source: nothing may be written.
        rst = 1'b0; syn_valid = 1'b1; syn_data = 32'hDEAD_0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_wrreq", 32'(fifo_wrreq), 32'd0);
            chk("idle_syn_ready", 32'(syn_ready), 32'd0);
        end
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_out_stop", 32'(out_stop), 32'd1);

        // Prefill from synth with fifo_used tracking writes.
        auto_used = 1'b1; cmd_play = 1'b1;
        tick();
        cmd_play = 1'b0;
        chk("pf_state", 32'(state), 32'd1);
        chk("pf_out_pause", 32'(out_pause), 32'd1);
        chk("pf_out_stop", 32'(out_stop), 32'd0);
        nwr = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (state != 2'd1) break;
            nwr += int'(fifo_wrreq);
        end
        chk("pf_writes", 32'(nwr), 32'd1024);
        chk("play_state", 32'(state), 32'd2);
        chk("play_out_pause", 32'(out_pause), 32'd0);

        // Watermark / full / source-select table in PLAY.
        auto_used = 1'b0;
        for (int i = 0; i < 7; i++) begin
            fifo_used = vecs[i].used; fifo_full = vecs[i].full;
            syn_valid = vecs[i].sv; pb_valid = vecs[i].pv;
            syn_data = vecs[i].dat; pb_data = ~vecs[i].dat;
            #1;
            chk($sformatf("tbl%0d_syn_ready", i), 32'(syn_ready), 32'(vecs[i].e_sr));
            chk($sformatf("tbl%0d_pb_ready", i), 32'(pb_ready), 32'(vecs[i].e_pr));
            tick();
            chk($sformatf("tbl%0d_wrreq", i), 32'(fifo_wrreq), 32'(vecs[i].e_wr));
            if (vecs[i].e_wr)
                chk($sformatf("tbl%0d_data", i), fifo_data, vecs[i].dat);
        end
        chk("tbl_state", 32'(state), 32'd2);

        // Pause keeps writing; play resumes without prefill.
        fifo_used = 12'd500; fifo_full = 0; syn_valid = 1; pb_valid = 0;
        cmd_pause = 1'b1;
        tick();
        cmd_pause = 1'b0;
        chk("pause_state", 32'(state), 32'd3);
        chk("pause_out_pause", 32'(out_pause), 32'd1);
        syn_data = 32'h1234_5678;
        tick();
        chk("pause_wrreq", 32'(fifo_wrreq), 32'd1);
        chk("pause_data", fifo_data, 32'h1234_5678);
        cmd_play = 1'b1;
        tick();
        cmd_play = 1'b0;
        chk("resume_state", 32'(state), 32'd2);
        chk("resume_out_pause", 32'(out_pause), 32'd0);

        // Underruns: three rising edges in PLAY, one in PAUSED, two more in PLAY.
        for (int i = 0; i < 3; i++) begin
            fifo_empty = 1'b1; tick();
            fifo_empty = 1'b0; tick();
        end
        chk("ur_cnt3", 32'(underrun_cnt), 32'd3);
        chk("ur_sat3", 32'(s_cnt), 32'd3);
        cmd_pause = 1'b1; tick(); cmd_pause = 1'b0;
        fifo_empty = 1'b1; tick();
        fifo_empty = 1'b0; tick();
        chk("ur_paused", 32'(underrun_cnt), 32'd3);
        cmd_play = 1'b1; tick(); cmd_play = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fifo_empty = 1'b1; tick();
            fifo_empty = 1'b0; tick();
        end
        chk("ur_cnt5", 32'(underrun_cnt), 32'd5);
        chk("ur_saturated", 32'(s_cnt), 32'd3);

        // src_sel change mid-PLAY is ignored; play+stop together stops.
        src_sel = 1'b1; pb_valid = 1'b1; syn_valid = 1'b1; fifo_used = 12'd500;
        #1;
        chk("mid_syn_ready", 32'(syn_ready), 32'd1);
        chk("mid_pb_ready", 32'(pb_ready), 32'd0);
        tick();
        cmd_play = 1'b1; cmd_stop = 1'b1;
        #1;
        chk("stop_ready_drop", 32'(syn_ready), 32'd0);
        tick();
        cmd_play = 1'b0; cmd_stop = 1'b0;
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_out_stop", 32'(out_stop), 32'd1);
        chk("stop_out_pause", 32'(out_pause), 32'd0);
        chk("stop_wrreq", 32'(fifo_wrreq), 32'd0);
        tick();
        chk("stop_wrreq2", 32'(fifo_wrreq), 32'd0);

        // New play latches src_sel=1: playback source is now the one served.
        pb_data = 32'hBEEF_0042;
        cmd_play = 1'b1;
        tick();
        cmd_play = 1'b0;
        chk("pb_state", 32'(state), 32'd1);
        chk("pb_pb_ready", 32'(pb_ready), 32'd1);
        chk("pb_syn_ready", 32'(syn_ready), 32'd0);
        tick();
        chk("pb_wrreq", 32'(fifo_wrreq), 32'd1);
        chk("pb_data", fifo_data, 32'hBEEF_0042);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        chk("pf_stop_state", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
